inject_arbiter: RTL

- Shares one router injection port (i_v/i_vc/i_x/i_y/i_data with i_ack) among N_REQ local traffic sources at one torus node.
- Each source uses the same valid/ack handshake the router presents. The arbiter picks one source round-robin, registers its packet onto the router port, holds it until i_ack, then returns a one-cycle ack to the winning source.
- Sits between the per-node token-bucket-regulated clients and the router injection port.

---
 rtl/inject_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/inject_arbiter.sv
// Round-robin arbiter that shares one router injection port among N_REQ local sources.
// The winning packet is registered onto the port and held until the router acks it.
module inject_arbiter #(
  parameter int N_REQ = 4,
  parameter int VC_W  = 3,
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int D_W   = 28,
  parameter int CNT_W = 16,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_v,
  input  logic [N_REQ*VC_W-1:0]  req_vc,
  input  logic [N_REQ*X_W-1:0]   req_x,
  input  logic [N_REQ*Y_W-1:0]   req_y,
  input  logic [N_REQ*D_W-1:0]   req_data,
  output logic [N_REQ-1:0]       req_ack,
  input  logic                   i_ack,
  output logic                   i_v,
  output logic [VC_W-1:0]        i_vc,
  output logic [X_W-1:0]         i_x,
  output logic [Y_W-1:0]         i_y,
  output logic [D_W-1:0]         i_data,
  output logic [IDX_W-1:0]       grant_idx,
  output logic [CNT_W-1:0]       sent_cnt,
  output logic                   err_ack
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_grant;
  logic [VC_W-1:0]   r_vc;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [D_W-1:0]    r_data;
  logic [CNT_W-1:0]  r_sent;
  logic              r_err_ack;

  logic [IDX_W-1:0]  w_base;
  logic              w_mask_en;
  logic [IDX_W-1:0]  w_pick;
  logic              w_found;
  logic              w_ack_send;
  logic [VC_W-1:0]   w_vc;
  logic [X_W-1:0]    w_x;
  logic [Y_W-1:0]    w_y;
  logic [D_W-1:0]    w_data;

  assign w_ack_send = (r_state == SEND) && i_ack;

  // On an ack the search starts just past the current owner and excludes it,
  // since its req_v still shows the packet that was just accepted.
  always_comb begin
    w_base    = r_ptr;
    w_mask_en = 1'b0;
    if (r_state == SEND) begin
      w_mask_en = 1'b1;
      if (32'(r_grant) == N_REQ - 1)
        w_base = '0;
      else
        w_base = r_grant + IDX_W'(1);
    end
  end

  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (32'(w_base) + off) % N_REQ;
      if (!w_found && req_v[idx] && !(w_mask_en && (idx == 32'(r_grant)))) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    w_vc   = req_vc[w_pick*VC_W +: VC_W];
    w_x    = req_x[w_pick*X_W +: X_W];
    w_y    = req_y[w_pick*Y_W +: Y_W];
    w_data = req_data[w_pick*D_W +: D_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_vc      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_data    <= '0;
      r_sent    <= '0;
      r_err_ack <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_ack)
            r_err_ack <= 1'b1;
          if (w_found) begin
            r_state <= SEND;
            r_grant <= w_pick;
            r_vc    <= w_vc;
            r_x     <= w_x;
            r_y     <= w_y;
            r_data  <= w_data;
          end
        end
        SEND: begin
          if (i_ack) begin
            r_sent <= r_sent + CNT_W'(1);
            r_ptr  <= w_base;
            if (w_found) begin
              r_grant <= w_pick;
              r_vc    <= w_vc;
              r_x     <= w_x;
              r_y     <= w_y;
              r_data  <= w_data;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ack = '0;
    if (w_ack_send)
      req_ack[r_grant] = 1'b1;
  end

  assign i_v       = (r_state == SEND);
  assign i_vc      = r_vc;
  assign i_x       = r_x;
  assign i_y       = r_y;
  assign i_data    = r_data;
  assign grant_idx = r_grant;
  assign sent_cnt  = r_sent;
  assign err_ack   = r_err_ack;

endmodule
